// File: rtl/bfs_pkg.sv
// Shared BFS controller types: FSM state encoding and software-visible status codes.
// State encoding keeps status equal to state[2:1], so the status decode is wiring only.
package bfs_pkg;

   localparam int unsigned ROOT_W = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      LAUNCH = 3'b010,
      RUN    = 3'b011,
      DRAIN  = 3'b100,
      CHECK  = 3'b101,
      DONE   = 3'b110
   } bfs_state_e;

   localparam logic [1:0] BFS_STATUS_IDLE    = 2'd0;
   localparam logic [1:0] BFS_STATUS_RUNNING = 2'd1;
   localparam logic [1:0] BFS_STATUS_SYNC    = 2'd2;
   localparam logic [1:0] BFS_STATUS_DONE    = 2'd3;

   function automatic logic [1:0] bfs_status(input bfs_state_e s);
      logic [1:0] v;
      case (s)
         LAUNCH, RUN:  v = BFS_STATUS_RUNNING;
         DRAIN, CHECK: v = BFS_STATUS_SYNC;
         DONE:         v = BFS_STATUS_DONE;
         default:      v = BFS_STATUS_IDLE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/bfs_popcount_acc.sv
// Per-cycle popcount of NUM_PE update strobes folded into a saturating CNT_W accumulator.
// i_clr discards the old total; combined with i_en the current popcount becomes the new total.
module bfs_popcount_acc #(
   parameter int unsigned NUM_PE = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [NUM_PE-1:0] i_bits,
   output logic [CNT_W-1:0]  o_acc
);

   localparam int unsigned PC_W  = $clog2(NUM_PE + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [PC_W-1:0]  w_pc;
   logic [CNT_W-1:0] w_base;
   logic [SUM_W-1:0] w_sum;
   logic [CNT_W-1:0] r_acc;

   always_comb begin
      w_pc = '0;
      for (int i = 0; i < int'(NUM_PE); i++) begin
         w_pc = w_pc + PC_W'(i_bits[i]);
      end
   end

   assign w_base = i_clr ? '0 : r_acc;
   assign w_sum  = {1'b0, w_base} + SUM_W'(w_pc);

   // Carry out of the add means the count has hit the ceiling.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      end else if (i_clr) begin
         r_acc <= '0;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/bfs_level_ctrl.sv
// Level-synchronous BFS controller: launches all PEs per level, waits for completion and a
// quiet crossbar, then advances the level (swapping frontier buffers) or finishes.
module bfs_level_ctrl
   import bfs_pkg::*;
#(
   parameter int unsigned NUM_PE    = 4,
   parameter int unsigned LEVEL_W   = 16,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned QUIET_CYC = 8
) (
   input  logic               gt_txusrclk,
   input  logic               peripheral_reset,
   input  logic               start,
   input  logic [ROOT_W-1:0]  root_vid,
   input  logic [LEVEL_W-1:0] max_level,
   output logic [NUM_PE-1:0]  pe_start,
   input  logic [NUM_PE-1:0]  pe_done,
   input  logic [NUM_PE-1:0]  upd_valid,
   input  logic               xbar_idle,
   output logic               frontier_sel,
   output logic [LEVEL_W-1:0] cur_level,
   output logic [ROOT_W-1:0]  root_out,
   output logic [1:0]         status,
   output logic [CNT_W-1:0]   last_frontier,
   output logic [CNT_W-1:0]   total_cycles
);

   localparam int unsigned QW    = $clog2(QUIET_CYC + 1);
   localparam int unsigned LVL1W = LEVEL_W + 1;

   bfs_state_e         r_state;
   logic [NUM_PE-1:0]  r_pe_start;
   logic [NUM_PE-1:0]  r_done_mask;
   logic [QW-1:0]      r_quiet;
   logic               r_frontier_sel;
   logic [LEVEL_W-1:0] r_cur_level;
   logic [ROOT_W-1:0]  r_root;
   logic [CNT_W-1:0]   r_last_frontier;
   logic [CNT_W-1:0]   r_total;

   logic [NUM_PE-1:0]  w_mask_nxt;
   logic [LVL1W-1:0]   w_lvl_inc;
   logic [CNT_W-1:0]   w_count;
   logic               w_accept;
   logic               w_busy;
   logic               w_acc_en;
   logic               w_acc_clr;
   logic               w_stop;

   assign w_mask_nxt = r_done_mask | pe_done;
   assign w_lvl_inc  = {1'b0, r_cur_level} + LVL1W'(1);
   assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_acc_en   = (r_state == LAUNCH) || (r_state == RUN) || (r_state == DRAIN);
   assign w_busy     = w_acc_en || (r_state == CHECK);
   assign w_acc_clr  = w_accept || (r_state == LAUNCH);

   // Stop on an empty next frontier, the level limit, or an exhausted level counter.
   assign w_stop = (w_count == '0) ||
                   ((max_level != '0) && (w_lvl_inc == {1'b0, max_level})) ||
                   (&r_cur_level);

   bfs_popcount_acc #(
      .NUM_PE (NUM_PE),
      .CNT_W  (CNT_W)
   ) u_frontier_cnt (
      .clk    (gt_txusrclk),
      .rst    (peripheral_reset),
      .i_clr  (w_acc_clr),
      .i_en   (w_acc_en),
      .i_bits (upd_valid),
      .o_acc  (w_count)
   );

   always_ff @(posedge gt_txusrclk) begin
      if (peripheral_reset) begin
         r_state         <= IDLE;
         r_pe_start      <= '0;
         r_done_mask     <= '0;
         r_quiet         <= '0;
         r_frontier_sel  <= 1'b0;
         r_cur_level     <= '0;
         r_root          <= '0;
         r_last_frontier <= '0;
         r_total         <= '0;
      end else begin
         r_pe_start <= '0;

         if (w_busy && (r_total != '1)) begin
            r_total <= r_total + CNT_W'(1);
         end

         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_root          <= root_vid;
                  r_cur_level     <= '0;
                  r_frontier_sel  <= 1'b0;
                  r_done_mask     <= '0;
                  r_last_frontier <= '0;
                  r_total         <= '0;
                  r_state         <= LAUNCH;
               end
            end
            // Done pulses seen while launching already count toward this level.
            LAUNCH: begin
               r_pe_start  <= '1;
               r_done_mask <= pe_done;
               r_quiet     <= '0;
               r_state     <= RUN;
            end
            RUN: begin
               r_done_mask <= w_mask_nxt;
               if (&w_mask_nxt) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (r_quiet == QW'(QUIET_CYC)) begin
                  r_state <= CHECK;
               end else if (xbar_idle) begin
                  r_quiet <= r_quiet + QW'(1);
               end else begin
                  r_quiet <= '0;
               end
            end
            CHECK: begin
               r_last_frontier <= w_count;
               if (w_stop) begin
                  r_state <= DONE;
               end else begin
                  r_cur_level    <= w_lvl_inc[LEVEL_W-1:0];
                  r_frontier_sel <= ~r_frontier_sel;
                  r_state        <= LAUNCH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pe_start      = r_pe_start;
   assign frontier_sel  = r_frontier_sel;
   assign cur_level     = r_cur_level;
   assign root_out      = r_root;
   assign status        = bfs_status(r_state);
   assign last_frontier = r_last_frontier;
   assign total_cycles  = r_total;

endmodule

// File: tb/tb_bfs_level_ctrl.sv
// Directed bench for bfs_level_ctrl: a table of whole traversals plus hand-timed corner sequences.
module tb_bfs_level_ctrl;
   import bfs_pkg::*;

   logic        clk;
   logic        peripheral_reset;
   logic        start;
   logic [31:0] root_vid;
   logic [15:0] max_level;
   logic [3:0]  pe_start;
   logic [3:0]  pe_done;
   logic [3:0]  upd_valid;
   logic        xbar_idle;
   logic        frontier_sel;
   logic [15:0] cur_level;
   logic [31:0] root_out;
   logic [1:0]  status;
   logic [31:0] last_frontier;
   logic [31:0] total_cycles;

   int total_n;
   int bad_n;
   int cyc;

   typedef struct packed {
      logic [31:0] root;
      logic [15:0] max_level;
      logic [31:0] upd_nib;     // nibble L = cycles of all-PE updates at level L
      logic [15:0] exp_level;
      logic        exp_sel;
      logic [31:0] exp_last;
      logic [7:0]  exp_bursts;
   } rec_t;

   rec_t vec [6];

   bfs_level_ctrl dut (
      .gt_txusrclk      (clk),
      .peripheral_reset (peripheral_reset),
      .start            (start),
      .root_vid         (root_vid),
      .max_level        (max_level),
      .pe_start         (pe_start),
      .pe_done          (pe_done),
      .upd_valid        (upd_valid),
      .xbar_idle        (xbar_idle),
      .frontier_sel     (frontier_sel),
      .cur_level        (cur_level),
      .root_out         (root_out),
      .status           (status),
      .last_frontier    (last_frontier),
      .total_cycles     (total_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int nib(input logic [31:0] v, input int l);
      logic [31:0] s;
      s = (v >> (4 * l)) & 32'hF;
      return int'(s);
   endfunction

   // Drive one complete traversal; every PE updates upd_nib[L] cycles then finishes together.
   task automatic run_rec(input rec_t r, input int idx);
      int   lvl;
      int   bursts;
      int   e0;
      bit   fin;
      bit   got;
      max_level = r.max_level;
      root_vid  = r.root;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      e0        = cyc;
      chk($sformatf("v%0d_status_launch", idx), 64'(status), 64'(BFS_STATUS_RUNNING));
      chk($sformatf("v%0d_level_cleared", idx), 64'(cur_level), 64'd0);
      chk($sformatf("v%0d_total_cleared", idx), 64'(total_cycles), 64'd0);
      chk($sformatf("v%0d_pe_start_early", idx), 64'(pe_start), 64'd0);
      tick();
      chk($sformatf("v%0d_pe_start_lat2", idx), 64'(pe_start), 64'hF);
      bursts = 1;
      lvl    = 0;
      fin    = 1'b0;
      while (!fin) begin
         upd_valid = 4'hF;
         repeat (nib(r.upd_nib, lvl)) tick();
         upd_valid = 4'h0;
         pe_done   = 4'hF;
         tick();
         pe_done   = 4'h0;
         got       = 1'b0;
         for (int g = 0; g < 40 && !got; g++) begin
            tick();
            if (pe_start == 4'hF) begin
               got = 1'b1;
               bursts++;
               lvl++;
            end else if (status == BFS_STATUS_DONE) begin
               got = 1'b1;
               fin = 1'b1;
            end
         end
         if (!got) begin
            chk($sformatf("v%0d_level_timeout", idx), 64'(status), 64'(BFS_STATUS_DONE));
            fin = 1'b1;
         end
         if (bursts > 20) fin = 1'b1;
      end
      chk($sformatf("v%0d_status_done", idx), 64'(status), 64'(BFS_STATUS_DONE));
      chk($sformatf("v%0d_cur_level", idx), 64'(cur_level), 64'(r.exp_level));
      chk($sformatf("v%0d_frontier_sel", idx), 64'(frontier_sel), 64'(r.exp_sel));
      chk($sformatf("v%0d_last_frontier", idx), 64'(last_frontier), 64'(r.exp_last));
      chk($sformatf("v%0d_bursts", idx), 64'(bursts), 64'(r.exp_bursts));
      chk($sformatf("v%0d_root_out", idx), 64'(root_out), 64'(r.root));
      chk($sformatf("v%0d_total_cycles", idx), 64'(total_cycles), 64'(cyc - e0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total_n = 0;
      bad_n   = 0;
      cyc     = 0;

      vec[0] = '{root: 32'd5,          max_level: 16'd0, upd_nib: 32'h0000_0222,
                 exp_level: 16'd3, exp_sel: 1'b1, exp_last: 32'd0,  exp_bursts: 8'd4};
      vec[1] = '{root: 32'd9,          max_level: 16'd2, upd_nib: 32'h3333_3333,
                 exp_level: 16'd1, exp_sel: 1'b1, exp_last: 32'd12, exp_bursts: 8'd2};
      vec[2] = '{root: 32'd77,         max_level: 16'd1, upd_nib: 32'h1111_1111,
                 exp_level: 16'd0, exp_sel: 1'b0, exp_last: 32'd4,  exp_bursts: 8'd1};
      vec[3] = '{root: 32'hDEAD_BEEF,  max_level: 16'd0, upd_nib: 32'h0000_0000,
                 exp_level: 16'd0, exp_sel: 1'b0, exp_last: 32'd0,  exp_bursts: 8'd1};
      vec[4] = '{root: 32'd3,          max_level: 16'd5, upd_nib: 32'h0065_4321,
                 exp_level: 16'd4, exp_sel: 1'b0, exp_last: 32'd20, exp_bursts: 8'd5};
      vec[5] = '{root: 32'd1,          max_level: 16'd0, upd_nib: 32'h0000_0011,
                 exp_level: 16'd2, exp_sel: 1'b0, exp_last: 32'd0,  exp_bursts: 8'd3};

      peripheral_reset = 1'b1;
      start     = 1'b0;
      root_vid  = 32'd0;
      max_level = 16'd0;
      pe_done   = 4'h0;
      upd_valid = 4'h0;
      xbar_idle = 1'b1;
      tick();
      tick();
      chk("rst_status", 64'(status), 64'd0);
      chk("rst_pe_start", 64'(pe_start), 64'd0);
      chk("rst_cur_level", 64'(cur_level), 64'd0);
      chk("rst_sel", 64'(frontier_sel), 64'd0);
      chk("rst_root", 64'(root_out), 64'd0);
      chk("rst_last", 64'(last_frontier), 64'd0);
      chk("rst_total", 64'(total_cycles), 64'd0);
      peripheral_reset = 1'b0;
      tick();

      // PE2 finishes 50 cycles late; crossbar idle drops every 5th cycle for a while.
      max_level = 16'd1;
      root_vid  = 32'd42;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      tick();
      chk("late_pe_start", 64'(pe_start), 64'hF);
      pe_done = 4'b1011;
      tick();
      pe_done = 4'h0;
      for (int k = 1; k <= 50; k++) begin
         xbar_idle = (k % 5) != 0;
         tick();
      end
      chk("late_still_run", 64'(status), 64'(BFS_STATUS_RUNNING));
      xbar_idle = 1'b1;
      pe_done   = 4'b0100;
      tick();
      pe_done   = 4'h0;
      for (int k = 1; k <= 20; k++) begin
         xbar_idle = !(((k % 5) == 0) && (k <= 10));
         tick();
         if (k == 19) chk("quiet_k19_sync", 64'(status), 64'(BFS_STATUS_SYNC));
         if (k == 20) chk("quiet_k20_done", 64'(status), 64'(BFS_STATUS_DONE));
      end
      chk("late_last", 64'(last_frontier), 64'd0);

      // Restart from DONE; 3 cycles of 4 updates; PE0 done during LAUNCH; stray start in RUN.
      max_level = 16'd1;
      root_vid  = 32'h1234;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      pe_done   = 4'b0001;
      upd_valid = 4'hF;
      tick();
      pe_done   = 4'h0;
      chk("burst_pe_start", 64'(pe_start), 64'hF);
      start     = 1'b1;
      root_vid  = 32'd99;
      tick();
      start     = 1'b0;
      tick();
      upd_valid = 4'h0;
      pe_done   = 4'b1110;
      tick();
      pe_done   = 4'h0;
      repeat (9) tick();
      chk("burst_sync_e13", 64'(status), 64'(BFS_STATUS_SYNC));
      tick();
      chk("burst_done_e14", 64'(status), 64'(BFS_STATUS_DONE));
      chk("burst_last12", 64'(last_frontier), 64'd12);
      chk("burst_total14", 64'(total_cycles), 64'd14);
      chk("burst_root_kept", 64'(root_out), 64'h1234);
      chk("burst_level", 64'(cur_level), 64'd0);

      // Reset while draining aborts everything.
      max_level = 16'd0;
      root_vid  = 32'd7;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      tick();
      pe_done   = 4'hF;
      upd_valid = 4'hF;
      tick();
      pe_done   = 4'h0;
      upd_valid = 4'h0;
      tick();
      chk("drain_status", 64'(status), 64'(BFS_STATUS_SYNC));
      peripheral_reset = 1'b1;
      tick();
      chk("mid_rst_status", 64'(status), 64'd0);
      chk("mid_rst_pe_start", 64'(pe_start), 64'd0);
      chk("mid_rst_total", 64'(total_cycles), 64'd0);
      chk("mid_rst_last", 64'(last_frontier), 64'd0);
      chk("mid_rst_root", 64'(root_out), 64'd0);
      peripheral_reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_rec(vec[i], i);
      end

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
